sprite_blitter: RTL and testbench
=================================

SPRITE_BLITTER -- requirements
Module: sprite_blitter

Interface
REQ-001 SHALL have parameter TRANSP_COLOR, default 16'hF81F: the sprite pixel value that is skipped (transparent).
REQ-002 SHALL have the following ports, listed as name, direction, width, meaning:
- clk, in, 1: the single clock; every register is clocked on its rising edge.
- reset, in, 1: synchronous, active-high reset.
- start, in, 1: one-cycle request; sampled only in IDLE.
- spr_base, in, 12: pic_mem word address of sprite pixel (0,0); row-major, packed.
- spr_w, in, 7: sprite width in pixels, 0..64.
- spr_h, in, 7: sprite height in pixels, 0..64.
- dst_x, in, 8: destination column, 0..255.
- dst_y, in, 7: destination row, 0..127.
- busy, out, 1: high from the cycle after an accepted start until DONE exits.
- done, out, 1: one-cycle completion pulse.
- pic_address, out, 12; pic_chipselect, out, 1; pic_clken, out, 1; pic_write, out, 1; pic_writedata, out, 16; pic_byteenable, out, 2: sprite-memory port-2 master.
- pic_readdata, in, 16: sprite read data, valid the cycle after the address is presented.
- bg_address, out, 13; bg_chipselect, out, 1; bg_clken, out, 1; bg_write, out, 1; bg_writedata, out, 16; bg_byteenable, out, 2: background-memory port-2 master.
- bg_readdata, in, 16: unused.

Function
REQ-003 SHALL treat the background as 128 columns x 64 rows of RGB565; the pixel at (x,y) is at address y*128+x.
REQ-004 SHALL implement an FSM with states IDLE, RD, WAIT, WR, DONE.
REQ-005 IDLE: when start=1, SHALL latch all arguments, clear col/row, and go to RD; if spr_w=0 or spr_h=0, SHALL go to DONE instead and issue no memory access.
REQ-006 RD: SHALL drive pic_address=spr_base+row*spr_w+col (modulo 2^12) with pic_chipselect=pic_clken=1, then go to WAIT.
REQ-007 WAIT: SHALL register pic_readdata into pix, then go to WR.
REQ-008 WR: SHALL assert bg_chipselect=bg_clken=bg_write=1 with bg_writedata=pix and bg_byteenable=2'b11, only if pix!=TRANSP_COLOR and the pixel is writable (REQ-015); otherwise all bg strobes SHALL stay low.
REQ-009 WR: SHALL advance col; at col=spr_w-1, col SHALL go to 0 and row SHALL increment; after the last pixel the FSM SHALL go to DONE, otherwise to RD.
REQ-010 Each pixel SHALL take exactly 3 cycles; done SHALL assert in DONE, exactly 3*spr_w*spr_h+1 cycles after the start cycle; DONE SHALL return to IDLE.
REQ-011 busy SHALL be high in RD, WAIT, WR and DONE; start while busy SHALL be ignored; latched arguments SHALL be unaffected by input changes during an operation.
REQ-012 pic_write SHALL be 0, pic_writedata 0 and pic_byteenable 2'b11 at all times; strobes on both ports SHALL be 0 outside their stated states.
REQ-013 The destination coordinate SHALL be computed at full width: x=dst_x+col (9 bits), y=dst_y+row (8 bits).

Reset
REQ-014 reset SHALL force IDLE, with busy, done and all chipselect/clken/write strobes at 0, addresses 0, pix 0 and col/row 0, on the next edge, including mid-operation; an aborted operation SHALL produce no done pulse and no further memory access.

Configuration
REQ-015 With SPRITE_BLITTER_CLIP_EN defined, a pixel SHALL be writable only if x<128 and y<64; otherwise it is skipped and its 3-cycle slot is kept. Without the macro, every pixel SHALL be writable, and bg_address SHALL be {y[5:0],x[6:0]} (wrap-around).

Verification
REQ-016 2x2 sprite, spr_base=0x010, at (10,5), pic data A,B,C,D (non-transparent) -> writes at 650, 651, 778, 779 with A..D; done pulses 13 cycles after start.
REQ-017 Same sprite with pixel B=16'hF81F -> no write at 651; other writes unchanged; done still at cycle 13.
REQ-018 4x1 sprite at (126,0): with CLIP_EN -> writes only 126 and 127; without it -> writes 126, 127, 0, 1; both cases take 13 cycles.
REQ-019 spr_w=0 -> done 1 cycle after start, busy high for 1 cycle, zero memory strobes.
REQ-020 Reset asserted in the WAIT of pixel 2 -> all strobes 0 and busy 0 from the next cycle; no done; a new start then completes normally.
REQ-021 A second start and changed arguments during an operation -> ignored; the write sequence and done timing match the first request.

Source files
------------

// File: rtl/sprite_blitter.sv
// Sprite blitter: copies a packed RGB565 sprite into a 128x64 background, skipping transparent pixels.
// Optional macro SPRITE_BLITTER_CLIP_EN drops pixels falling outside the background instead of wrapping.
module sprite_blitter #(
  parameter logic [15:0] TRANSP_COLOR = 16'hF81F
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [11:0] spr_base,
  input  logic [6:0]  spr_w,
  input  logic [6:0]  spr_h,
  input  logic [7:0]  dst_x,
  input  logic [6:0]  dst_y,
  output logic        busy,
  output logic        done,
  output logic [11:0] pic_address,
  output logic        pic_chipselect,
  output logic        pic_clken,
  output logic        pic_write,
  output logic [15:0] pic_writedata,
  output logic [1:0]  pic_byteenable,
  input  logic [15:0] pic_readdata,
  output logic [12:0] bg_address,
  output logic        bg_chipselect,
  output logic        bg_clken,
  output logic        bg_write,
  output logic [15:0] bg_writedata,
  output logic [1:0]  bg_byteenable,
  input  logic [15:0] bg_readdata
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_WAIT = 3'd2,
    S_WR   = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [11:0] base_q, base_d;
  logic [6:0]  w_q, w_d;
  logic [6:0]  h_q, h_d;
  logic [7:0]  dx_q, dx_d;
  logic [6:0]  dy_q, dy_d;
  logic [6:0]  col_q, col_d;
  logic [6:0]  row_q, row_d;
  logic [11:0] idx_q, idx_d;
  logic [15:0] pix_q, pix_d;

  logic [8:0]  x_full;
  logic [7:0]  y_full;
  logic        last_col;
  logic        last_pix;
  logic        writable;
  logic        do_write;

  // idx_q is the linear pixel index row*spr_w+col, so no multiplier is needed
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      col_q   <= 7'd0;
      row_q   <= 7'd0;
      idx_q   <= 12'd0;
      pix_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      idx_q   <= idx_d;
      pix_q   <= pix_d;
    end
  end

  always_ff @(posedge clk) begin
    base_q <= base_d;
    w_q    <= w_d;
    h_q    <= h_d;
    dx_q   <= dx_d;
    dy_q   <= dy_d;
  end

  assign last_col = (col_q == w_q - 7'd1);
  assign last_pix = last_col && (row_q == h_q - 7'd1);

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    w_d     = w_q;
    h_d     = h_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    col_d   = col_q;
    row_d   = row_q;
    idx_d   = idx_q;
    pix_d   = pix_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          base_d  = spr_base;
          w_d     = spr_w;
          h_d     = spr_h;
          dx_d    = dst_x;
          dy_d    = dst_y;
          col_d   = 7'd0;
          row_d   = 7'd0;
          idx_d   = 12'd0;
          state_d = (spr_w == 7'd0 || spr_h == 7'd0) ? S_DONE : S_RD;
        end
      end
      S_RD: state_d = S_WAIT;
      S_WAIT: begin
        pix_d   = pic_readdata;
        state_d = S_WR;
      end
      S_WR: begin
        idx_d = idx_q + 12'd1;
        if (last_col) begin
          col_d = 7'd0;
          row_d = row_q + 7'd1;
        end else begin
          col_d = col_q + 7'd1;
        end
        state_d = last_pix ? S_DONE : S_RD;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign x_full = {1'b0, dx_q} + {2'b00, col_q};
  assign y_full = {1'b0, dy_q} + {1'b0, row_q};

`ifdef SPRITE_BLITTER_CLIP_EN
  assign writable = (x_full < 9'd128) && (y_full < 8'd64);
  logic unused_bits;
  assign unused_bits = ^bg_readdata;
`else
  assign writable = 1'b1;
  // Without clipping the high coordinate bits are discarded and the image wraps
  logic unused_bits;
  assign unused_bits = ^{bg_readdata, x_full[8:7], y_full[7:6]};
`endif

  assign do_write = (state_q == S_WR) && (pix_q != TRANSP_COLOR) && writable;

  always_comb begin
    busy           = 1'b0;
    done           = 1'b0;
    pic_address    = 12'd0;
    pic_chipselect = 1'b0;
    pic_clken      = 1'b0;
    pic_write      = 1'b0;
    pic_writedata  = 16'd0;
    pic_byteenable = 2'b11;
    bg_address     = 13'd0;
    bg_chipselect  = 1'b0;
    bg_clken       = 1'b0;
    bg_write       = 1'b0;
    bg_writedata   = 16'd0;
    bg_byteenable  = 2'b00;
    unique case (state_q)
      S_IDLE: busy = 1'b0;
      S_RD: begin
        busy           = 1'b1;
        pic_address    = base_q + idx_q;
        pic_chipselect = 1'b1;
        pic_clken      = 1'b1;
      end
      S_WAIT: busy = 1'b1;
      S_WR: begin
        busy = 1'b1;
        if (do_write) begin
          bg_address    = {y_full[5:0], x_full[6:0]};
          bg_chipselect = 1'b1;
          bg_clken      = 1'b1;
          bg_write      = 1'b1;
          bg_writedata  = pix_q;
          bg_byteenable = 2'b11;
        end
      end
      S_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: busy = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_sprite_blitter.sv
// Scoreboard bench for sprite_blitter: a pixel-loop reference model queues expected background
// writes and done cycles; a negedge monitor pops and compares them as the DUT produces them.
module tb_sprite_blitter;

`ifdef SPRITE_BLITTER_CLIP_EN
  localparam bit CLIP = 1'b1;
`else
  localparam bit CLIP = 1'b0;
`endif
  localparam logic [15:0] TC = 16'hF81F;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [11:0] spr_base = 12'd0;
  logic [6:0]  spr_w = 7'd0;
  logic [6:0]  spr_h = 7'd0;
  logic [7:0]  dst_x = 8'd0;
  logic [6:0]  dst_y = 7'd0;
  logic        busy, done;
  logic [11:0] pic_address;
  logic        pic_chipselect, pic_clken, pic_write;
  logic [15:0] pic_writedata;
  logic [1:0]  pic_byteenable;
  logic [15:0] pic_readdata = 16'd0;
  logic [12:0] bg_address;
  logic        bg_chipselect, bg_clken, bg_write;
  logic [15:0] bg_writedata;
  logic [1:0]  bg_byteenable;
  logic [15:0] bg_readdata = 16'd0;

  sprite_blitter dut (
    .clk(clk), .reset(reset), .start(start), .spr_base(spr_base),
    .spr_w(spr_w), .spr_h(spr_h), .dst_x(dst_x), .dst_y(dst_y),
    .busy(busy), .done(done),
    .pic_address(pic_address), .pic_chipselect(pic_chipselect), .pic_clken(pic_clken),
    .pic_write(pic_write), .pic_writedata(pic_writedata), .pic_byteenable(pic_byteenable),
    .pic_readdata(pic_readdata),
    .bg_address(bg_address), .bg_chipselect(bg_chipselect), .bg_clken(bg_clken),
    .bg_write(bg_write), .bg_writedata(bg_writedata), .bg_byteenable(bg_byteenable),
    .bg_readdata(bg_readdata)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [12:0] a;
    logic [15:0] d;
  } wr_t;

  logic [15:0] pic_mem [4096];
  wr_t         exp_wr_q[$];
  int          exp_done_q[$];
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  int          pic_acc_cnt = 0;
  int          bg_acc_cnt = 0;

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (pic_chipselect && pic_clken) pic_readdata <= pic_mem[pic_address];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: port invariants, background writes and done pulses
  always @(negedge clk) begin
    wr_t e;
    int  ed;
    check("pic_write_const", {15'd0, pic_write, pic_writedata}, 32'd0);
    check("pic_be_const", {30'd0, pic_byteenable}, 32'd3);
    check("pic_cs_eq_clken", {31'd0, pic_chipselect}, {31'd0, pic_clken});
    if (pic_chipselect || pic_clken) pic_acc_cnt++;
    if (bg_chipselect || bg_clken || bg_write) begin
      bg_acc_cnt++;
      check("bg_strobes", {27'd0, bg_chipselect, bg_clken, bg_write, bg_byteenable}, 32'h1F);
      n_checks++;
      if (exp_wr_q.size() == 0) begin
        n_fail++;
        $display("FAIL bg_unexpected_write: actual addr=%0d data=%0h required none (cycle %0d)",
                 bg_address, bg_writedata, cyc);
      end else begin
        e = exp_wr_q.pop_front();
        check("bg_address", {19'd0, bg_address}, {19'd0, e.a});
        check("bg_writedata", {16'd0, bg_writedata}, {16'd0, e.d});
      end
    end
    if (done) begin
      check("busy_in_done", {31'd0, busy}, 32'd1);
      n_checks++;
      if (exp_done_q.size() == 0) begin
        n_fail++;
        $display("FAIL done_unexpected: actual done=1 required 0 (cycle %0d)", cyc);
      end else begin
        ed = exp_done_q.pop_front();
        check("done_cycle", cyc, ed);
      end
    end
  end

  // Reference model: visit every sprite pixel in row-major order up to 'limit' pixels
  task automatic push_model(input int base, input int w, input int h, input int dx,
                            input int dy, input int limit);
    int x, y, idx;
    logic [15:0] p;
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        idx = r * w + c;
        if (idx >= limit) continue;
        p = pic_mem[(base + idx) % 4096];
        x = dx + c;
        y = dy + r;
        if (p == TC) continue;
        if (CLIP && (x >= 128 || y >= 64)) continue;
        exp_wr_q.push_back('{a: 13'((y % 64) * 128 + (x % 128)), d: p});
      end
    end
  endtask

  task automatic drive_start(input int base, input int w, input int h, input int dx,
                             input int dy, output int s);
    start    = 1'b1;
    spr_base = 12'(base);
    spr_w    = 7'(w);
    spr_h    = 7'(h);
    dst_x    = 8'(dx);
    dst_y    = 7'(dy);
    s        = cyc;
  endtask

  // Runs one operation; expected writes must already be queued. Optionally disturbs inputs while busy.
  task automatic run_op(input int base, input int w, input int h, input int dx, input int dy,
                        input bit wiggle);
    int s, len;
    len = 3 * w * h + 1;
    @(negedge clk);
    drive_start(base, w, h, dx, dy, s);
    exp_done_q.push_back(s + len);
    for (int k = 1; k <= len; k++) begin
      @(negedge clk);
      check("busy_during_op", {31'd0, busy}, 32'd1);
      if (wiggle) begin
        start    = 1'($urandom);
        spr_base = 12'($urandom);
        spr_w    = 7'($urandom_range(1, 64));
        spr_h    = 7'($urandom_range(1, 64));
        dst_x    = 8'($urandom);
        dst_y    = 7'($urandom);
      end else begin
        start = 1'b0;
      end
    end
    @(negedge clk);
    start = 1'b0;
    check("busy_after_done", {31'd0, busy}, 32'd0);
    check("done_after_done", {31'd0, done}, 32'd0);
    check("done_seen", exp_done_q.size(), 0);
    check("writes_all_seen", exp_wr_q.size(), 0);
    exp_done_q.delete();
    exp_wr_q.delete();
  endtask

  initial begin
    int s, w, h, b, dx, dy, pc0, bc0;
    for (int i = 0; i < 4096; i++)
      pic_mem[i] = ($urandom_range(0, 3) == 0) ? TC : 16'($urandom);

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_busy_done", {30'd0, busy, done}, 32'd0);
    check("rst_strobes", {26'd0, pic_chipselect, pic_clken, bg_chipselect, bg_clken,
                          bg_write, 1'b0}, 32'd0);
    check("rst_addr", {7'd0, bg_address, pic_address}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // 2x2 sprite, all opaque
    pic_mem[12'h010] = 16'h1111;
    pic_mem[12'h011] = 16'h2222;
    pic_mem[12'h012] = 16'h3333;
    pic_mem[12'h013] = 16'h4444;
    exp_wr_q.push_back('{a: 13'd650, d: 16'h1111});
    exp_wr_q.push_back('{a: 13'd651, d: 16'h2222});
    exp_wr_q.push_back('{a: 13'd778, d: 16'h3333});
    exp_wr_q.push_back('{a: 13'd779, d: 16'h4444});
    run_op(12'h010, 2, 2, 10, 5, 1'b0);

    // Transparent pixel B is skipped
    pic_mem[12'h011] = TC;
    exp_wr_q.push_back('{a: 13'd650, d: 16'h1111});
    exp_wr_q.push_back('{a: 13'd778, d: 16'h3333});
    exp_wr_q.push_back('{a: 13'd779, d: 16'h4444});
    run_op(12'h010, 2, 2, 10, 5, 1'b0);

    // 4x1 sprite crossing the right edge
    for (int i = 0; i < 4; i++) pic_mem[12'h100 + i] = 16'h0A00 + 16'(i);
    exp_wr_q.push_back('{a: 13'd126, d: 16'h0A00});
    exp_wr_q.push_back('{a: 13'd127, d: 16'h0A01});
    if (!CLIP) begin
      exp_wr_q.push_back('{a: 13'd0, d: 16'h0A02});
      exp_wr_q.push_back('{a: 13'd1, d: 16'h0A03});
    end
    run_op(12'h100, 4, 1, 126, 0, 1'b0);

    // Zero-size sprites: done one cycle after start, no memory traffic
    pc0 = pic_acc_cnt;
    bc0 = bg_acc_cnt;
    run_op(12'h020, 0, 5, 3, 3, 1'b0);
    run_op(12'h020, 5, 0, 3, 3, 1'b0);
    check("zero_size_pic_access", pic_acc_cnt - pc0, 0);
    check("zero_size_bg_access", bg_acc_cnt - bc0, 0);

    // Reset during the WAIT of pixel 2
    pic_mem[12'h200] = 16'h5555;
    push_model(12'h200, 3, 2, 20, 7, 1);
    @(negedge clk);
    drive_start(12'h200, 3, 2, 20, 7, s);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("abort_busy_done", {30'd0, busy, done}, 32'd0);
    check("abort_strobes", {27'd0, pic_chipselect, pic_clken, bg_chipselect, bg_clken,
                            bg_write}, 32'd0);
    check("abort_addr", {7'd0, bg_address, pic_address}, 32'd0);
    reset = 1'b0;
    pc0 = pic_acc_cnt;
    repeat (10) @(negedge clk);
    check("abort_quiet_pic", pic_acc_cnt - pc0, 0);
    check("abort_busy_idle", {31'd0, busy}, 32'd0);
    check("abort_pixel1_written", exp_wr_q.size(), 0);
    exp_wr_q.delete();
    push_model(12'h200, 3, 2, 20, 7, 1 << 30);
    run_op(12'h200, 3, 2, 20, 7, 1'b0);

    // Second start and changing arguments during an operation are ignored
    pic_mem[12'h011] = 16'h2222;
    push_model(12'h010, 2, 2, 10, 5, 1 << 30);
    run_op(12'h010, 2, 2, 10, 5, 1'b1);

    // Randomized operations
    for (int n = 0; n < 30; n++) begin
      w  = (n == 0) ? 64 : $urandom_range(0, 9);
      h  = (n == 0) ? 64 : $urandom_range(0, 9);
      b  = $urandom_range(0, 4095);
      dx = $urandom_range(0, 255);
      dy = $urandom_range(0, 127);
      push_model(b, w, h, dx, dy, 1 << 30);
      run_op(b, w, h, dx, dy, 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
